// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer
//  Description : Serial-in, parallel-out receiver with valid/ready word output
//                and a sticky overrun flag for words lost to back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ser_in,
    input  logic                 ser_valid,
    input  logic                 msb_first,
    input  logic                 clear,
    input  logic                 out_ready,
    output logic [N-1:0]         data_out,
    output logic                 out_valid,
    output logic                 overrun,
    output logic [$clog2(N)-1:0] bit_count
);

    localparam int CW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [N-1:0]    r_acc_q, w_acc_d;
    logic [N-1:0]    r_data_q, w_data_d;
    logic [CW-1:0]   r_cnt_q, w_cnt_d;
    logic            r_valid_q, w_valid_d;
    logic            r_ovr_q, w_ovr_d;
    logic            r_msb_q, w_msb_d;

    logic            w_order;
    logic [N-1:0]    w_shifted;

    // Bit order is taken live on the first bit of a word, then frozen.
    assign w_order   = (r_state_q == IDLE) ? msb_first : r_msb_q;
    assign w_shifted = w_order ? {r_acc_q[N-2:0], ser_in} : {ser_in, r_acc_q[N-1:1]};

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_data_d  = r_data_q;
        w_cnt_d   = r_cnt_q;
        w_valid_d = r_valid_q;
        w_ovr_d   = r_ovr_q;
        w_msb_d   = r_msb_q;

        if (r_valid_q && out_ready) begin
            w_valid_d = 1'b0;
        end

        if (clear) begin
            w_acc_d   = '0;
            w_cnt_d   = '0;
            w_ovr_d   = 1'b0;
            w_state_d = IDLE;
        end else if (ser_valid) begin
            w_msb_d = w_order;
            w_acc_d = w_shifted;
            if (r_cnt_q == CW'(N - 1)) begin
                w_cnt_d   = '0;
                w_state_d = IDLE;
                // A completed word only lands if the output slot is free now.
                if (!r_valid_q || out_ready) begin
                    w_data_d  = w_shifted;
                    w_valid_d = 1'b1;
                end else begin
                    w_ovr_d = 1'b1;
                end
            end else begin
                w_cnt_d   = r_cnt_q + CW'(1);
                w_state_d = RECV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_acc_q   <= '0;
            r_data_q  <= '0;
            r_cnt_q   <= '0;
            r_valid_q <= 1'b0;
            r_ovr_q   <= 1'b0;
            r_msb_q   <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_data_q  <= w_data_d;
            r_cnt_q   <= w_cnt_d;
            r_valid_q <= w_valid_d;
            r_ovr_q   <= w_ovr_d;
            r_msb_q   <= w_msb_d;
        end
    end

    assign data_out  = r_data_q;
    assign out_valid = r_valid_q;
    assign overrun   = r_ovr_q;
    assign bit_count = r_cnt_q;

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver. It assembles N-bit words from a qualified serial bit stream and presents each completed word on a valid/ready parallel output. It is the receive-side counterpart to the parallel-load shift/serializer datapath. It sits between a serial link front end and a parallel word consumer, and it flags words lost to back-pressure.

## Interface
- N, 16: word width in bits; N ≥ 2; counter width CW = $clog2(N)
- clk  input  1  rising-edge clock; all state changes on this edge
- reset  input  1  synchronous, active-high reset
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in is a valid bit this cycle
- msb_first  input  1  bit order: 1 = first bit received lands in data_out[N-1]; 0 = first bit lands in data_out[0]
- clear  input  1  synchronous abort of the partial word and clear of overrun
- out_ready  input  1  consumer accepts data_out this cycle
- data_out  output  N  last completed word
- out_valid  output  1  data_out holds an unconsumed word
- overrun  output  1  sticky flag: a completed word was dropped
- bit_count  output  CW  bits received of the current partial word, 0..N-1

## Operation
- Receive FSM has two states:
  - IDLE: bit_count = 0.
  - RECV: 0 < bit_count < N.
  - IDLE → RECV on ser_valid.
  - RECV → IDLE on the Nth valid bit, or on clear.
- Order latch: msb_first is sampled on the first valid bit of a word (IDLE with ser_valid). The latched value holds for the whole word. Changes to msb_first mid-word are ignored.
- Shift on ser_valid = 1:
  - MSB-first: acc ← {acc[N-2:0], ser_in}.
  - LSB-first: acc ← {ser_in, acc[N-1:1]}.
  - bit_count increments.
- Shift on ser_valid = 0: acc and bit_count hold. Gaps of any length between bits are legal.
- Completion: ser_valid = 1 while bit_count = N-1.
  - The completed word is the post-shift acc value.
  - bit_count ← 0.
  - Output behaviour depends on output state:
    - out_valid = 0, or (out_valid = 1 and out_ready = 1): data_out ← word, out_valid ← 1.
    - out_valid = 1 and out_ready = 0: the word is dropped, data_out and out_valid hold, overrun ← 1.
- Handshake:
  - A word is consumed on any cycle with out_valid = 1 and out_ready = 1.
  - If there is no completion in the same cycle, out_valid ← 0 next cycle; data_out keeps its value.
  - out_ready while out_valid = 0 has no effect.
- clear:
  - acc ← 0, bit_count ← 0, overrun ← 0; the FSM goes to IDLE.
  - It has priority over ser_valid in the same cycle; that bit is discarded.
  - out_valid and data_out are unaffected, and a handshake in the same cycle still completes.
- overrun is sticky. Only clear or reset clear it.

## Timing
- Reset, asserted on a clock edge, sets: data_out = 0, out_valid = 0, overrun = 0, bit_count = 0, acc = 0, FSM = IDLE, order latch = MSB-first.
- Reset overrides every other input in the same cycle.
- Reset mid-word discards the partial word.
- Latency: data_out and out_valid update on the same edge that samples the Nth valid bit. The word is visible in the following cycle.
- Throughput: one bit per cycle. Back-to-back words with ser_valid held high are lossless if out_ready = 1 on each completion cycle.
- bit_count is registered and reflects bits already sampled.

## Test plan
- Clean MSB-first receive:
  - Stimulus: reset, then 16 consecutive bits of 0xA5C3, MSB-first, msb_first = 1, out_ready = 0.
  - Required: out_valid = 1 and data_out = 0xA5C3 one cycle after the 16th bit; bit_count = 0.
- LSB-first with gaps:
  - Stimulus: bits of 0x1234 sent LSB-first with msb_first = 0, ser_valid toggled 1,0,1,0…; then msb_first toggled mid-word.
  - Required: data_out = 0x1234; the mid-word toggle is ignored.
- Back-to-back words:
  - Stimulus: words 0xFFFF then 0x0001 with ser_valid held high and out_ready = 1.
  - Required: out_valid is high on both completion+1 cycles; data_out = 0xFFFF, then 0x0001; overrun = 0.
- Overrun:
  - Stimulus: receive 0x00FF with out_ready = 0; then receive 0xBEEF with out_ready still 0.
  - Required: data_out stays 0x00FF, overrun = 1.
  - Then: one cycle with out_ready = 1 → out_valid = 0 and overrun stays 1; pulse clear → overrun = 0.
- Clear and reset mid-word:
  - Stimulus: 7 bits received (bit_count = 7); assert clear together with ser_valid.
  - Required: bit_count = 0; the next 16 bits form a correct word.
  - Then: repeat with reset mid-word and a word pending → all outputs zero next cycle.
